// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer
// Sequences LANES-element vector loads and stores over the single-port data
// memory, one element per cycle, and arbitrates that port against scalar
// load/store traffic coming from the pipeline.
//
// The accept cycle (IDLE with vec_req high) already issues element 0 on the
// memory port, straight from vec_base/vec_wdata. Elements 1..LANES-1 follow
// from the latched copies. Loads need one extra VDRAIN cycle because the
// memory read data arrives one cycle after its address.
//
// Optional feature macro: VEC_SEQ_STRIDE_EN
//   Defined   : adds the 8-bit vec_stride input; element k is read or written
//               at base + k*stride, modulo 2^ADDR_WIDTH. The address comes
//               from a running adder, so there is no multiplier.
//   Undefined : no vec_stride port; the stride is fixed at 1.

module vector_mem_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 16,
   parameter int ADDR_WIDTH = 19
) (
   input  logic                          clk,
   input  logic                          rst,

   input  logic                          vec_req,
   input  logic                          vec_we,
   input  logic [ADDR_WIDTH-1:0]         vec_base,
`ifdef VEC_SEQ_STRIDE_EN
   input  logic [7:0]                    vec_stride,
`endif
   input  logic [LANES*DATA_WIDTH-1:0]   vec_wdata,
   output logic [LANES*DATA_WIDTH-1:0]   vec_rdata,
   output logic                          vec_done,
   output logic                          stall,

   input  logic                          scal_req,
   input  logic                          scal_we,
   input  logic [ADDR_WIDTH-1:0]         scal_addr,
   input  logic [DATA_WIDTH-1:0]         scal_wdata,
   output logic                          scal_gnt,

   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic                          mem_we,
   output logic [DATA_WIDTH-1:0]         mem_wdata,
   input  logic [DATA_WIDTH-1:0]         mem_rdata
);

   localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

   typedef enum logic [2:0] {
      IDLE,
      VLOAD,
      VDRAIN,
      VSTORE,
      DONE
   } state_t;

   state_t                 state;
   logic [CW-1:0]          lane_cnt;
   logic [ADDR_WIDTH-1:0]  elem_addr;
   logic [ADDR_WIDTH-1:0]  stride_q;
   logic [ADDR_WIDTH-1:0]  stride_in;
   logic [DATA_WIDTH-1:0]  wlane_q [LANES];
   logic [DATA_WIDTH-1:0]  rlane_q [LANES];

`ifdef VEC_SEQ_STRIDE_EN
   assign stride_in = ADDR_WIDTH'(vec_stride);
`else
   assign stride_in = ADDR_WIDTH'(1);
`endif

   // Sequencer FSM: it latches the operation on accept, then steps the lane
   // counter and the running element address once per cycle. Load data is
   // captured one cycle after the matching address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         lane_cnt  <= '0;
         elem_addr <= '0;
         stride_q  <= '0;
         for (int i = 0; i < LANES; i++) begin
            wlane_q[i] <= '0;
            rlane_q[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (vec_req) begin
                  for (int i = 0; i < LANES; i++) begin
                     wlane_q[i] <= vec_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                  end
                  stride_q  <= stride_in;
                  elem_addr <= vec_base + stride_in;
                  lane_cnt  <= CW'(1);
                  state     <= vec_we ? VSTORE : VLOAD;
               end
            end
            VLOAD: begin
               rlane_q[lane_cnt - CW'(1)] <= mem_rdata;
               elem_addr <= elem_addr + stride_q;
               lane_cnt  <= lane_cnt + CW'(1);
               if (lane_cnt == LAST_LANE) begin
                  state <= VDRAIN;
               end
            end
            VDRAIN: begin
               rlane_q[LANES-1] <= mem_rdata;
               lane_cnt         <= '0;
               state            <= DONE;
            end
            VSTORE: begin
               elem_addr <= elem_addr + stride_q;
               lane_cnt  <= lane_cnt + CW'(1);
               if (lane_cnt == LAST_LANE) begin
                  lane_cnt <= '0;
                  state    <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state    <= IDLE;
               lane_cnt <= '0;
            end
         endcase
      end
   end

   // Memory port mux and pipeline handshake. A vector request takes the port
   // in its accept cycle and beats a simultaneous scalar request. A scalar
   // request is granted only in IDLE (with no vector request) and in DONE.
   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      scal_gnt  = 1'b0;
      stall     = 1'b0;
      case (state)
         IDLE: begin
            if (vec_req) begin
               stall    = 1'b1;
               mem_addr = vec_base;
               mem_we   = vec_we;
               if (vec_we) begin
                  mem_wdata = vec_wdata[DATA_WIDTH-1:0];
               end
            end else if (scal_req) begin
               scal_gnt  = 1'b1;
               mem_addr  = scal_addr;
               mem_we    = scal_we;
               mem_wdata = scal_wdata;
            end
         end
         VLOAD: begin
            stall    = 1'b1;
            mem_addr = elem_addr;
         end
         VDRAIN: begin
            stall = 1'b1;
         end
         VSTORE: begin
            stall     = 1'b1;
            mem_addr  = elem_addr;
            mem_we    = 1'b1;
            mem_wdata = wlane_q[lane_cnt];
         end
         DONE: begin
            if (scal_req) begin
               scal_gnt  = 1'b1;
               mem_addr  = scal_addr;
               mem_we    = scal_we;
               mem_wdata = scal_wdata;
            end
         end
         default: begin
            stall = 1'b0;
         end
      endcase
   end

   // The completion pulse is exactly the single DONE cycle.
   assign vec_done = (state == DONE);

   // Pack the lane registers into the flat result bus, with lane k in bits
   // [k*DATA_WIDTH +: DATA_WIDTH].
   always_comb begin
      vec_rdata = '0;
      for (int i = 0; i < LANES; i++) begin
         vec_rdata[i*DATA_WIDTH +: DATA_WIDTH] = rlane_q[i];
      end
   end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// tb_vector_mem_sequencer
// Directed bench for vector_mem_sequencer, with a single-port memory model
// that has a synchronous read. Inputs change 1 ns after the rising edge and
// outputs are sampled on the falling edge.
// Optional feature macro: VEC_SEQ_STRIDE_EN enables the strided-load step.

module tb_vector_mem_sequencer;

   localparam int DW    = 16;
   localparam int LANES = 16;
   localparam int AW    = 19;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 vec_req;
   logic                 vec_we;
   logic [AW-1:0]        vec_base;
`ifdef VEC_SEQ_STRIDE_EN
   logic [7:0]           vec_stride;
`endif
   logic [LANES*DW-1:0]  vec_wdata;
   logic [LANES*DW-1:0]  vec_rdata;
   logic                 vec_done;
   logic                 stall;
   logic                 scal_req;
   logic                 scal_we;
   logic [AW-1:0]        scal_addr;
   logic [DW-1:0]        scal_wdata;
   logic                 scal_gnt;
   logic [AW-1:0]        mem_addr;
   logic                 mem_we;
   logic [DW-1:0]        mem_wdata;
   logic [DW-1:0]        mem_rdata;

   logic [DW-1:0]        mem [0:(1<<AW)-1];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   vector_mem_sequencer #(
      .DATA_WIDTH (DW),
      .LANES      (LANES),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .vec_req    (vec_req),
      .vec_we     (vec_we),
      .vec_base   (vec_base),
`ifdef VEC_SEQ_STRIDE_EN
      .vec_stride (vec_stride),
`endif
      .vec_wdata  (vec_wdata),
      .vec_rdata  (vec_rdata),
      .vec_done   (vec_done),
      .stall      (stall),
      .scal_req   (scal_req),
      .scal_we    (scal_we),
      .scal_addr  (scal_addr),
      .scal_wdata (scal_wdata),
      .scal_gnt   (scal_gnt),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // Single-port memory: a write on the edge, and registered read data.
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic req, input logic we, input logic [AW-1:0] base);
      vec_req  = req;
      vec_we   = we;
      vec_base = base;
   endtask

   task automatic scalarWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(posedge clk); #1;
      scal_req = 1'b1; scal_we = 1'b1; scal_addr = a; scal_wdata = d;
      @(posedge clk); #1;
      scal_req = 1'b0; scal_we = 1'b0;
   endtask

   // Runs one vector op on a fixed cycle schedule and stops at the DONE
   // cycle's falling edge. After the accept cycle the inputs are scrambled,
   // so a design that fails to latch them is caught.
   task automatic runVector(input string tag, input logic we, input logic [AW-1:0] base,
                            input logic with_scal);
      logic [LANES*DW-1:0] sent;
      logic [AW-1:0]       exp_addr;
      logic [AW-1:0]       step;
      int                  busy;
      sent = vec_wdata;
      busy = we ? LANES : LANES + 1;
`ifdef VEC_SEQ_STRIDE_EN
      step = AW'(vec_stride);
`else
      step = AW'(1);
`endif
      @(posedge clk); #1;
      applyStimulus(1'b1, we, base);
      if (with_scal) begin
         scal_req = 1'b1; scal_we = 1'b1; scal_addr = 19'h00050; scal_wdata = 16'h1234;
      end
      exp_addr = base;
      for (int i = 0; i < busy; i++) begin
         @(negedge clk);
         checkOutput({tag, "_stall"}, 32'(stall), 32'd1);
         checkOutput({tag, "_gnt"}, 32'(scal_gnt), 32'd0);
         checkOutput({tag, "_done_early"}, 32'(vec_done), 32'd0);
         if (i < LANES) begin
            checkOutput({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
            checkOutput({tag, "_we"}, 32'(mem_we), 32'(we));
            if (we) checkOutput({tag, "_wdata"}, 32'(mem_wdata), 32'(sent[i*DW +: DW]));
         end else begin
            checkOutput({tag, "_drain_we"}, 32'(mem_we), 32'd0);
         end
         exp_addr = exp_addr + step;
         @(posedge clk); #1;
         vec_req   = 1'b0;
         vec_base  = ~base;
         vec_wdata = ~sent;
`ifdef VEC_SEQ_STRIDE_EN
         vec_stride = vec_stride + 8'd3;
`endif
      end
      @(negedge clk);
      checkOutput({tag, "_done"}, 32'(vec_done), 32'd1);
      checkOutput({tag, "_done_stall"}, 32'(stall), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, '0);
      vec_wdata = '0;
`ifdef VEC_SEQ_STRIDE_EN
      vec_stride = 8'd1;
`endif
      scal_req = 1'b0; scal_we = 1'b0; scal_addr = '0; scal_wdata = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_stall", 32'(stall), 32'd0);
      checkOutput("reset_done", 32'(vec_done), 32'd0);
      checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
      checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
      checkOutput("reset_mem_wdata", 32'(mem_wdata), 32'd0);
      checkOutput("reset_rdata_nonzero", 32'(vec_rdata !== '0), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // A scalar read in IDLE is granted and drives the port
      @(posedge clk); #1;
      scal_req = 1'b1; scal_we = 1'b0; scal_addr = 19'h00123;
      @(negedge clk);
      checkOutput("scal_idle_gnt", 32'(scal_gnt), 32'd1);
      checkOutput("scal_idle_addr", 32'(mem_addr), 32'h123);
      checkOutput("scal_idle_we", 32'(mem_we), 32'd0);
      checkOutput("scal_idle_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      scal_req = 1'b0;

      // Preload the memory through the scalar path
      for (int k = 0; k < LANES; k++) scalarWrite(AW'(32'h100 + k), DW'(32'hA000 + k));
      scalarWrite(19'h7FFFE, 16'hBEE0);
      scalarWrite(19'h7FFFF, 16'hBEE1);
      scalarWrite(19'h00000, 16'hBEE2);
      scalarWrite(19'h0000D, 16'hBEEF);

      // Vector load from 0x100
      runVector("load", 1'b0, 19'h00100, 1'b0);
      for (int k = 0; k < LANES; k++)
         checkOutput("load_lane", 32'(vec_rdata[k*DW +: DW]), 32'hA000 + k);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("load_done_pulse_end", 32'(vec_done), 32'd0);

      // Vector store to 0x200
      for (int k = 0; k < LANES; k++) vec_wdata[k*DW +: DW] = DW'(32'h5500 + k);
      runVector("store", 1'b1, 19'h00200, 1'b0);
      @(posedge clk); #1;
      for (int k = 0; k < LANES; k++)
         checkOutput("store_readback", 32'(mem[19'h200 + k]), 32'h5500 + k);
      checkOutput("store_keeps_rdata0", 32'(vec_rdata[0 +: DW]), 32'hA000);
      checkOutput("store_keeps_rdata15", 32'(vec_rdata[15*DW +: DW]), 32'hA00F);

      // Address wrap past all-ones
      runVector("wrap", 1'b0, 19'h7FFFE, 1'b0);
      checkOutput("wrap_lane0", 32'(vec_rdata[0 +: DW]), 32'hBEE0);
      checkOutput("wrap_lane1", 32'(vec_rdata[1*DW +: DW]), 32'hBEE1);
      checkOutput("wrap_lane2", 32'(vec_rdata[2*DW +: DW]), 32'hBEE2);
      checkOutput("wrap_lane15", 32'(vec_rdata[15*DW +: DW]), 32'hBEEF);

      // Arbitration: the vector wins, the scalar write lands in DONE
      runVector("arb", 1'b0, 19'h00100, 1'b1);
      checkOutput("arb_done_gnt", 32'(scal_gnt), 32'd1);
      checkOutput("arb_done_addr", 32'(mem_addr), 32'h50);
      checkOutput("arb_done_we", 32'(mem_we), 32'd1);
      checkOutput("arb_done_wdata", 32'(mem_wdata), 32'h1234);
      @(posedge clk); #1;
      scal_req = 1'b0; scal_we = 1'b0;
      checkOutput("arb_scalar_landed", 32'(mem[19'h50]), 32'h1234);
      checkOutput("arb_rdata_lane3", 32'(vec_rdata[3*DW +: DW]), 32'hA003);

      // Reset in the middle of a store
      for (int k = 0; k < LANES; k++) scalarWrite(AW'(32'h200 + k), 16'h0000);
      @(posedge clk); #1;
      for (int k = 0; k < LANES; k++) vec_wdata[k*DW +: DW] = DW'(32'h5500 + k);
      applyStimulus(1'b1, 1'b1, 19'h00200);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         vec_req = 1'b0;
      end
      rst = 1'b1;
      #1;
      checkOutput("rstmid_stall", 32'(stall), 32'd0);
      checkOutput("rstmid_we", 32'(mem_we), 32'd0);
      checkOutput("rstmid_done", 32'(vec_done), 32'd0);
      checkOutput("rstmid_rdata_nonzero", 32'(vec_rdata !== '0), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput("rstmid_no_done", 32'(vec_done), 32'd0);
         checkOutput("rstmid_no_write", 32'(mem_we), 32'd0);
      end
      for (int k = 0; k < LANES; k++)
         checkOutput("rstmid_mem", 32'(mem[19'h200 + k]), (k < 5) ? 32'h5500 + k : 32'h0);

`ifdef VEC_SEQ_STRIDE_EN
      // Strided load: base 0x10 with stride 4
      for (int k = 0; k < LANES; k++) scalarWrite(AW'(32'h10 + 4*k), DW'(32'hC000 + k));
      vec_stride = 8'd4;
      runVector("stride", 1'b0, 19'h00010, 1'b0);
      for (int k = 0; k < LANES; k++)
         checkOutput("stride_lane", 32'(vec_rdata[k*DW +: DW]), 32'hC000 + k);
`endif

      @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
